// File: rtl/rs_fifo_relay.sv
// Registered FIFO-handshake relay: LEVEL forward/backward register stages plus a sink-side skid FIFO.
// Define RS_FIFO_RELAY_STATS_EN to add the stat_max_occ high-watermark and sticky err_overflow outputs.
module rs_fifo_relay #(
    parameter int DATA_WIDTH = 32,
    parameter int LEVEL      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter     __REGION   = "",
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout
`ifdef RS_FIFO_RELAY_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_max_occ,
    output logic                  err_overflow
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    if (LEVEL > 0 && FIFO_DEPTH < 2 * LEVEL + 2) begin : g_bad_depth
        $error("rs_fifo_relay%s: FIFO_DEPTH=%0d is below 2*LEVEL+2=%0d", __REGION, FIFO_DEPTH, 2 * LEVEL + 2);
    end

    // Pointers wrap explicitly so non-power-of-2 depths stay inside the buffer.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    if (LEVEL == 0) begin : g_bypass
        assign if_dout    = if_din;
        assign if_empty_n = if_write;
        assign if_full_n  = if_read;
`ifdef RS_FIFO_RELAY_STATS_EN
        assign stat_max_occ = '0;
        assign err_overflow = 1'b0;
`endif
    end else begin : g_relay
        // Words that can still land after space drops: LEVEL in flight plus LEVEL+1 accepted on stale ready.
        localparam int THRESH = FIFO_DEPTH - 2 * LEVEL - 1;

        logic [LEVEL-1:0]      s_v;
        logic [DATA_WIDTH-1:0] s_d [LEVEL];
        logic [LEVEL-1:0]      r;
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      count;
        logic                  accept;
        logic                  push;
        logic                  do_push;
        logic                  pop;
        logic                  space;

        assign accept = if_write && if_full_n;
        assign push   = s_v[LEVEL-1];
        assign pop    = if_read && (count != '0);
        assign space  = (count <= CNT_W'(THRESH));

`ifdef RS_FIFO_RELAY_STATS_EN
        assign do_push = push && !((count == CNT_W'(FIFO_DEPTH)) && !pop);
`else
        assign do_push = push;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s_v <= '0;
                r   <= '0;
            end else begin
                s_v[0] <= accept;
                r[0]   <= space;
                for (int k = 1; k < LEVEL; k++) begin
                    s_v[k] <= s_v[k-1];
                    r[k]   <= r[k-1];
                end
            end
        end

        // NOTE: payload registers and the buffer array carry no reset; validity lives only in s_v and count.
        always_ff @(posedge clk) begin
            s_d[0] <= if_din;
            for (int k = 1; k < LEVEL; k++) begin
                s_d[k] <= s_d[k-1];
            end
            if (do_push) begin
                mem[wr_ptr] <= s_d[LEVEL-1];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                if (do_push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !do_push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end

`ifdef RS_FIFO_RELAY_STATS_EN
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stat_max_occ <= '0;
                err_overflow <= 1'b0;
            end else begin
                if (count > stat_max_occ) begin
                    stat_max_occ <= count;
                end
                if (push && !pop && (count == CNT_W'(FIFO_DEPTH))) begin
                    err_overflow <= 1'b1;
                end
            end
        end
`endif

        assign if_full_n  = r[LEVEL-1];
        assign if_empty_n = (count != '0);
        assign if_dout    = mem[rd_ptr];
    end

endmodule

// File: tb/tb_rs_fifo_relay.sv
// Scoreboard bench for rs_fifo_relay: one pass-through instance and three registered lanes
// (LEVEL/FIFO_DEPTH = 2/6, 3/8, 1/5) checked against an in-order queue model of accepted words.
module tb_rs_fifo_relay;

    localparam int DW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pass-through instance (LEVEL=0, DATA_WIDTH=8).
    logic       wr0, rd0, full0, empty0;
    logic [7:0] din0, dout0;

    // Registered lanes: 0 -> L2/D6, 1 -> L3/D8, 2 -> L1/D5.
    logic          wr      [3];
    logic          rd      [3];
    logic [DW-1:0] din     [3];
    logic          full_n  [3];
    logic          empty_n [3];
    logic [DW-1:0] dout    [3];

    // Reference model: each lane is an ordered stream of accepted words awaiting delivery.
    logic [DW-1:0] exp_q [3][$];

`ifdef RS_FIFO_RELAY_STATS_EN
    logic [2:0] sm0, sm_a, sm_c;
    logic [3:0] sm_b;
    logic       ov0, ov_a, ov_b, ov_c;
`endif

    rs_fifo_relay #(.DATA_WIDTH(8), .LEVEL(0), .FIFO_DEPTH(4)) u_l0 (
        .clk(clk), .reset(reset), .if_full_n(full0), .if_write(wr0), .if_din(din0),
        .if_empty_n(empty0), .if_read(rd0), .if_dout(dout0)
`ifdef RS_FIFO_RELAY_STATS_EN
        , .stat_max_occ(sm0), .err_overflow(ov0)
`endif
    );

    rs_fifo_relay #(.DATA_WIDTH(DW), .LEVEL(2), .FIFO_DEPTH(6)) u_a (
        .clk(clk), .reset(reset), .if_full_n(full_n[0]), .if_write(wr[0]), .if_din(din[0]),
        .if_empty_n(empty_n[0]), .if_read(rd[0]), .if_dout(dout[0])
`ifdef RS_FIFO_RELAY_STATS_EN
        , .stat_max_occ(sm_a), .err_overflow(ov_a)
`endif
    );

    rs_fifo_relay #(.DATA_WIDTH(DW), .LEVEL(3), .FIFO_DEPTH(8)) u_b (
        .clk(clk), .reset(reset), .if_full_n(full_n[1]), .if_write(wr[1]), .if_din(din[1]),
        .if_empty_n(empty_n[1]), .if_read(rd[1]), .if_dout(dout[1])
`ifdef RS_FIFO_RELAY_STATS_EN
        , .stat_max_occ(sm_b), .err_overflow(ov_b)
`endif
    );

    rs_fifo_relay #(.DATA_WIDTH(DW), .LEVEL(1), .FIFO_DEPTH(5)) u_c (
        .clk(clk), .reset(reset), .if_full_n(full_n[2]), .if_write(wr[2]), .if_din(din[2]),
        .if_empty_n(empty_n[2]), .if_read(rd[2]), .if_dout(dout[2])
`ifdef RS_FIFO_RELAY_STATS_EN
        , .stat_max_occ(sm_c), .err_overflow(ov_c)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Words a lane may hold at once: FIFO_DEPTH in the buffer plus LEVEL in the forward stages.
    function automatic int lane_bound(input int i);
        case (i)
            0:       return 6 + 2;
            1:       return 8 + 3;
            default: return 5 + 1;
        endcase
    endfunction

    // One clock of stimulus on lane i; the word is logged as expected the moment it is accepted.
    task automatic step(input int i, input bit w, input bit r, input logic [DW-1:0] d,
                        output bit acc, output bit vld);
        wr[i]  = w;
        rd[i]  = r;
        din[i] = d;
        @(negedge clk);
        acc = w && (full_n[i] === 1'b1);
        vld = (empty_n[i] === 1'b1);
        if (acc) exp_q[i].push_back(d);
        @(posedge clk);
        #1;
        check($sformatf("lane%0d_occupancy_bound", i), 32'(exp_q[i].size() <= lane_bound(i)), 32'd1);
    endtask

    // Monitor: whenever a lane presents a word that the consumer takes, it must be the oldest accepted one.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() == 0) begin
                check($sformatf("lane%0d_valid_without_word", i), 32'(empty_n[i]), 32'd0);
            end else if (rd[i] === 1'b1 && empty_n[i] === 1'b1) begin
                check($sformatf("lane%0d_dout", i), 32'(dout[i]), 32'(exp_q[i][0]));
                void'(exp_q[i].pop_front());
            end
        end
    end

    initial begin
        bit            acc, vld;
        int            held, n_acc, cyc;
        logic [DW-1:0] seq;

        wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
        for (int i = 0; i < 3; i++) begin
            wr[i] = 1'b0; rd[i] = 1'b0; din[i] = '0;
        end

        // Reset state, observed while reset is held.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("lane%0d_reset_full_n", i), 32'(full_n[i]), 32'd0);
            check($sformatf("lane%0d_reset_empty_n", i), 32'(empty_n[i]), 32'd0);
        end
`ifdef RS_FIFO_RELAY_STATS_EN
        check("a_reset_stat_max_occ", 32'(sm_a), 32'd0);
        check("a_reset_err_overflow", 32'(ov_a), 32'd0);
`endif

        // LEVEL=0 is combinational and ignores reset.
        din0 = 8'hA5; wr0 = 1'b1; rd0 = 1'b0;
        #1;
        check("l0_dout_a5", 32'(dout0), 32'h A5);
        check("l0_empty_n", 32'(empty0), 32'd1);
        check("l0_full_n", 32'(full0), 32'd0);
        for (int k = 0; k < 8; k++) begin
            din0 = 8'($urandom);
            wr0  = 1'($urandom);
            rd0  = 1'($urandom);
            #1;
            check("l0_rand_dout", 32'(dout0), 32'(din0));
            check("l0_rand_empty_n", 32'(empty0), 32'(wr0));
            check("l0_rand_full_n", 32'(full0), 32'(rd0));
        end

        // Release; lane A writes 1,2,3,... with the consumer stalled.
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr[0] = 1'b1; din[0] = 16'd1; rd[0] = 1'b0;
        @(negedge clk);
        check("a_full_n_at_edge1", 32'(full_n[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("a_full_n_at_edge2", 32'(full_n[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("a_full_n_at_edge3", 32'(full_n[0]), 32'd1);
        exp_q[0].push_back(16'd1);   // accepted at edge 3
        @(posedge clk);
        #1;
        seq = 16'd2;
        for (int c = 0; c < 30; c++) begin
            step(0, 1'b1, 1'b0, seq, acc, vld);
            if (acc) seq++;
            // Step c samples just before edge c+4; word 1 must show at edge 6 and not at edge 5.
            if (c == 1) check("a_latency_not_early", 32'(vld), 32'd0);
            if (c == 2) begin
                check("a_latency_valid", 32'(vld), 32'd1);
                check("a_first_word", 32'(dout[0]), 32'd1);
            end
        end
        held = exp_q[0].size();
        check("a_stall_full_n_low", 32'(full_n[0]), 32'd0);
        check("a_stall_held_le_depth", 32'(held <= 6), 32'd1);
        check("a_stall_held_gt_thresh", 32'(held >= 2), 32'd1);
        check("a_stall_accept_count", 32'(seq - 16'd1), 32'(held));
`ifdef RS_FIFO_RELAY_STATS_EN
        check("a_stat_max_occ", 32'(sm_a), 32'(held));
        check("a_err_overflow", 32'(ov_a), 32'd0);
`endif
        // Everything is in the buffer, so the drain must pop one word per cycle.
        for (int c = 0; c < held; c++) step(0, 1'b0, 1'b1, 16'd0, acc, vld);
        check("a_drain_no_gaps", 32'(exp_q[0].size()), 32'd0);
        for (int c = 0; c < 6; c++) step(0, 1'b0, 1'b1, 16'd0, acc, vld);
        check("a_recovered_full_n", 32'(full_n[0]), 32'd1);

        // Lane C: non-power-of-2 depth, 20 back-to-back words with a free-running consumer.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 20 && cyc < 100) begin
            step(2, 1'b1, 1'b1, DW'(n_acc), acc, vld);
            if (acc) n_acc++;
            cyc++;
        end
        check("c_accepted", 32'(n_acc), 32'd20);
        check("c_full_rate", 32'(cyc), 32'd20);
        for (int c = 0; c < 10; c++) step(2, 1'b0, 1'b1, 16'd0, acc, vld);
        check("c_drained", 32'(exp_q[2].size()), 32'd0);

        // Lane B: random traffic at 50% on both sides.
        for (int c = 0; c < 10000; c++) begin
            step(1, 1'($urandom), 1'($urandom), DW'($urandom), acc, vld);
        end
        for (int c = 0; c < 40; c++) step(1, 1'b0, 1'b1, 16'd0, acc, vld);
        check("b_drained", 32'(exp_q[1].size()), 32'd0);
`ifdef RS_FIFO_RELAY_STATS_EN
        check("b_err_overflow", 32'(ov_b), 32'd0);
`endif

        // Lane A: buffer four words, then reset mid-cycle.
        n_acc = 0;
        cyc   = 0;
        seq   = 16'h0100;
        while (n_acc < 4 && cyc < 20) begin
            step(0, 1'b1, 1'b0, seq, acc, vld);
            if (acc) begin
                n_acc++;
                seq++;
            end
            cyc++;
        end
        for (int c = 0; c < 6; c++) step(0, 1'b0, 1'b0, 16'd0, acc, vld);
        check("a_buffered_four", 32'(exp_q[0].size()), 32'd4);
        check("a_buffered_valid", 32'(empty_n[0]), 32'd1);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        check("a_midreset_empty_n", 32'(empty_n[0]), 32'd0);
        check("a_midreset_full_n", 32'(full_n[0]), 32'd0);
`ifdef RS_FIFO_RELAY_STATS_EN
        check("a_midreset_stat_max_occ", 32'(sm_a), 32'd0);
        check("a_midreset_err_overflow", 32'(ov_a), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        // Fresh traffic after release; any stale word would surface as a dout or empty-queue miscompare.
        for (int c = 0; c < 300; c++) begin
            step(0, 1'($urandom), 1'($urandom), 16'h8000 | DW'(c), acc, vld);
        end
        for (int c = 0; c < 30; c++) step(0, 1'b0, 1'b1, 16'd0, acc, vld);
        check("a_post_reset_drained", 32'(exp_q[0].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
